// File: rtl/bus_rr_router_gen2.sv
// Round-robin arbiter/router: pops one show-ahead FIFO at a time and unicasts or broadcasts the packet.
// Min 4 cycles per packet; push waits until no target is full; bad destinations dropped and counted.
module bus_rr_router_gen2 #(
    parameter int              PCKG_SZ = 16,
    parameter int              DRVS    = 4,
    parameter int              ID_W    = 8,
    parameter logic [ID_W-1:0] BCAST   = 8'hFF,
    parameter int              CNT_W   = 16,
    localparam int             GW      = $clog2(DRVS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DRVS-1:0]         pndng,
    input  logic [DRVS*PCKG_SZ-1:0] D_pop,
    output logic [DRVS-1:0]         pop,
    input  logic [DRVS-1:0]         full,
    output logic [DRVS-1:0]         push,
    output logic [PCKG_SZ-1:0]      D_push,
    output logic                    busy,
    output logic [GW-1:0]           grant_id,
    output logic                    drop_pulse,
    output logic [CNT_W-1:0]        drop_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_POP, S_ROUTE, S_PUSH, S_DROP} state_t;

    state_t               state;
    logic [GW-1:0]        last_grant;
    logic [GW-1:0]        nxt_grant;
    logic [PCKG_SZ-1:0]   pkt_q;
    logic [DRVS-1:0]      mask_q;
    logic [ID_W-1:0]      dst;
    logic [DRVS-1:0]      src_oh;
    logic [DRVS-1:0]      uni;
    logic [DRVS-1:0]      tmask;
    logic                 route_ok;
    logic                 found;

    assign D_push = pkt_q;

    // First pending port strictly after last_grant, wrapping.
    always_comb begin
        nxt_grant = last_grant;
        found     = 1'b0;
        for (int off = 1; off <= DRVS; off++) begin
            int idx;
            idx = int'(last_grant) + off;
            if (idx >= DRVS) idx = idx - DRVS;
            if (!found && pndng[idx]) begin
                found     = 1'b1;
                nxt_grant = GW'(idx);
            end
        end
    end

    // The source bit is always masked off, so self-destination yields an empty mask.
    always_comb begin
        dst    = pkt_q[PCKG_SZ-1 -: ID_W];
        src_oh = '0;
        src_oh[grant_id] = 1'b1;
        for (int i = 0; i < DRVS; i++) uni[i] = (dst == ID_W'(i));
        if (dst == BCAST) tmask = ~src_oh;
        else              tmask = uni & ~src_oh;
        route_ok = |tmask;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            last_grant <= GW'(DRVS - 1);
            grant_id   <= '0;
            pop        <= '0;
            push       <= '0;
            pkt_q      <= '0;
            mask_q     <= '0;
            busy       <= 1'b0;
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|pndng) begin
                        grant_id   <= nxt_grant;
                        last_grant <= nxt_grant;
                        pop        <= DRVS'(1) << nxt_grant;
                        busy       <= 1'b1;
                        state      <= S_POP;
                    end
                end
                S_POP: begin
                    pop   <= '0;
                    pkt_q <= D_pop[grant_id*PCKG_SZ +: PCKG_SZ];
                    state <= S_ROUTE;
                end
                S_ROUTE: begin
                    if (route_ok) begin
                        mask_q <= tmask;
                        if ((full & tmask) == '0) push <= tmask;
                        state <= S_PUSH;
                    end else begin
                        drop_pulse <= 1'b1;
                        if (~&drop_cnt) drop_cnt <= drop_cnt + 1'b1;
                        state <= S_DROP;
                    end
                end
                S_PUSH: begin
                    // A non-zero push means the strobe just went out this cycle.
                    if (|push) begin
                        push  <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if ((full & mask_q) == '0) begin
                        push <= mask_q;
                    end
                end
                S_DROP: begin
                    drop_pulse <= 1'b0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_rr_router_gen2.sv
// Directed bench for bus_rr_router_gen2 (DRVS=4, PCKG_SZ=16, CNT_W=2).
module tb_bus_rr_router_gen2;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  pndng;
    logic [63:0] d_pop;
    logic [3:0]  pop;
    logic [3:0]  full;
    logic [3:0]  push;
    logic [15:0] d_push;
    logic        busy;
    logic [1:0]  grant_id;
    logic        drop_pulse;
    logic [1:0]  drop_cnt;

    int checks = 0;
    int fails  = 0;

    logic [3:0]  rr_pop  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0]  rr_gnt  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0]  rr_push [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [15:0] rr_dat  [5] = '{16'h01A0, 16'h02A1, 16'h03A2, 16'h00A3, 16'h01A0};
    logic [15:0] bad_pkt [5] = '{16'h0900, 16'h0412, 16'h0333, 16'h7F00, 16'h0501};

    bus_rr_router_gen2 #(.PCKG_SZ(16), .DRVS(4), .ID_W(8), .BCAST(8'hFF), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop), .pop(pop), .full(full),
        .push(push), .D_push(d_push), .busy(busy), .grant_id(grant_id),
        .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a packet on one port, wait for its pop, then advance to two cycles after the pop.
    task automatic send_pkt(input int port, input logic [15:0] data);
        d_pop[port*16 +: 16] = data;
        pndng[port] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (pop != 4'b0) break;
        end
        chk("pop_strobe", pop, 32'(4'b0001 << port));
        pndng[port] = 1'b0;
        step();
        chk("pop_one_cycle", pop, 0);
        step();
    endtask

    initial begin
        reset = 1'b1;
        pndng = '0;
        d_pop = '0;
        full  = '0;
        #12;
        chk("rst_pop", pop, 0);
        chk("rst_push", push, 0);
        chk("rst_dpush", d_push, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_cnt", drop_cnt, 0);
        @(negedge clk);
        reset = 1'b0;

        // T2 unicast port 1 -> port 2
        send_pkt(1, 16'h02AB);
        chk("t2_grant", grant_id, 1);
        chk("t2_push", push, 4'b0100);
        chk("t2_dpush", d_push, 16'h02AB);
        step();
        chk("t2_push_clr", push, 0);
        chk("t2_idle", busy, 0);

        // T1 reset while stalled on a full target
        full = 4'b0100;
        send_pkt(1, 16'h02CD);
        chk("t1_stall_push", push, 0);
        chk("t1_stall_busy", busy, 1);
        step();
        step();
        chk("t1_still_held", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t1_rst_busy", busy, 0);
        chk("t1_rst_push", push, 0);
        chk("t1_rst_dpush", d_push, 0);
        chk("t1_rst_grant", grant_id, 0);
        full = '0;
        @(negedge clk);
        reset = 1'b0;

        // T3 round-robin with every port pending
        for (int p = 0; p < 4; p++) d_pop[p*16 +: 16] = rr_dat[p];
        pndng = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 20; i++) begin
                step();
                if (pop != 4'b0) break;
            end
            chk("t3_pop", pop, rr_pop[n]);
            chk("t3_grant", grant_id, rr_gnt[n]);
            step();
            step();
            chk("t3_push", push, rr_push[n]);
            chk("t3_dpush", d_push, rr_dat[n]);
            if (n == 4) pndng = '0;
        end
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            step();
        end
        chk("t3_drain", busy, 0);

        // T4 broadcast from port 2 with port 0 full
        full = 4'b0001;
        d_pop[2*16 +: 16] = 16'hFF55;
        pndng[2] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (pop != 4'b0) break;
        end
        chk("t4_pop", pop, 4'b0100);
        pndng[2] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_no_push", push, 0);
        end
        chk("t4_busy", busy, 1);
        full = '0;
        step();
        chk("t4_push", push, 4'b1011);
        chk("t4_dpush", d_push, 16'hFF55);
        step();
        chk("t4_push_clr", push, 0);
        chk("t4_idle", busy, 0);

        // T5 invalid and self destinations
        send_pkt(0, 16'h0712);
        chk("t5a_pulse", drop_pulse, 1);
        chk("t5a_push", push, 0);
        chk("t5a_cnt", drop_cnt, 1);
        step();
        chk("t5a_pulse_clr", drop_pulse, 0);
        chk("t5a_push2", push, 0);
        send_pkt(0, 16'h0034);
        chk("t5b_pulse", drop_pulse, 1);
        chk("t5b_push", push, 0);
        chk("t5b_cnt", drop_cnt, 2);
        step();
        chk("t5b_idle", busy, 0);

        // T6 counter saturation
        for (int n = 0; n < 5; n++) begin
            send_pkt(3, bad_pkt[n]);
            chk("t6_pulse", drop_pulse, 1);
            chk("t6_push", push, 0);
            chk("t6_cnt", drop_cnt, 2'b11);
            step();
        end
        chk("t6_final_cnt", drop_cnt, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
